// File: rtl/mt_stack_unit.sv
// rtl/mt_stack_unit.sv - multi-thread operand-stack engine, one micro-op per cycle, registered result
// Per-thread stacks share one storage array indexed {thread, depth-1-n}; faulting threads halt until TRESET.
module mt_stack_unit #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 256,
   parameter int THREADS = 2,
   parameter int TW      = (THREADS > 1) ? $clog2(THREADS) : 1,
   parameter int CW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_valid,
   input  logic [TW-1:0]      op_thread,
   input  logic [3:0]         op_code,
   input  logic [CW-2:0]      op_arg,
   input  logic [WIDTH-1:0]   op_data,
   output logic               res_valid,
   output logic [TW-1:0]      res_thread,
   output logic [WIDTH-1:0]   res_top,
   output logic [CW-1:0]      res_count,
   output logic               fault,
   output logic [THREADS-1:0] halted
);
   localparam int AW = CW - 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [3:0] {
      OP_NOP    = 4'b0000,
      OP_GET    = 4'b0001,
      OP_POP    = 4'b0010,
      OP_PUT    = 4'b0011,
      OP_PUSH   = 4'b1000,
      OP_ADD    = 4'b1001,
      OP_SUB    = 4'b1010,
      OP_AND    = 4'b1011,
      OP_OR     = 4'b1100,
      OP_XOR    = 4'b1101,
      OP_LT     = 4'b1110,
      OP_TRESET = 4'b1111
   } op_e;

   logic [WIDTH-1:0]   mem_q [THREADS][DEPTH];
   logic [CW-1:0]      count_q [THREADS];
   logic [THREADS-1:0] halted_q, halted_d;
   logic               res_valid_q, fault_q;
   logic [TW-1:0]      res_thread_q;
   logic [WIDTH-1:0]   res_top_q;
   logic [CW-1:0]      res_count_q;

   op_e              op;
   logic [TW-1:0]    th;
   logic [CW-1:0]    d, cnt_d;
   logic [AW-1:0]    idx_m1, idx_m2, idx_mn;
   logic             has1, has2, room, n_ok;
   logic [WIDTH-1:0] t, s, nth, alu, top_d, wr_data;
   logic [AW-1:0]    wr_idx;
   logic             wr_en, flt;

   assign op = op_e'(op_code);
   assign th = (THREADS > 1) ? op_thread : '0;
   assign d  = count_q[th];

   // Storage is a flop array, so reads see last cycle's writes with no bypass needed.
   assign idx_m1 = AW'(d - CW'(1));
   assign idx_m2 = AW'(d - CW'(2));
   assign idx_mn = AW'(d - CW'(1) - {1'b0, op_arg});
   assign has1   = (d != '0);
   assign has2   = (d >= CW'(2));
   assign room   = (d < FULL);
   assign n_ok   = ({1'b0, op_arg} < d);
   assign t      = has1 ? mem_q[th][idx_m1] : '0;
   assign s      = mem_q[th][idx_m2];
   assign nth    = mem_q[th][idx_mn];

   always_comb begin
      alu = '0;
      case (op)
         OP_ADD:  alu = s + t;
         OP_SUB:  alu = s - t;
         OP_AND:  alu = s & t;
         OP_OR:   alu = s | t;
         OP_XOR:  alu = s ^ t;
         OP_LT:   alu = ($signed(s) < $signed(t)) ? WIDTH'(1) : '0;
         default: alu = '0;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = d[AW-1:0];
      wr_data  = op_data;
      cnt_d    = d;
      top_d    = t;
      flt      = 1'b0;
      halted_d = halted_q;
      if (halted_q[th] && (op != OP_TRESET)) begin
         flt = 1'b1;
      end else begin
         case (op)
            OP_NOP: begin
            end
            OP_GET: begin
               if (n_ok && room) begin
                  wr_en   = 1'b1;
                  wr_data = nth;
                  cnt_d   = d + CW'(1);
                  top_d   = nth;
               end else begin
                  flt = 1'b1;
               end
            end
            OP_POP: begin
               if (has1) begin
                  cnt_d = d - CW'(1);
                  top_d = has2 ? s : '0;
               end else begin
                  flt = 1'b1;
               end
            end
            OP_PUT: begin
               if (n_ok) begin
                  wr_en   = 1'b1;
                  wr_idx  = idx_mn;
                  wr_data = t;
               end else begin
                  flt = 1'b1;
               end
            end
            OP_PUSH: begin
               if (room) begin
                  wr_en   = 1'b1;
                  wr_data = op_data;
                  cnt_d   = d + CW'(1);
                  top_d   = op_data;
               end else begin
                  flt = 1'b1;
               end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT: begin
               if (has2) begin
                  wr_en   = 1'b1;
                  wr_idx  = idx_m2;
                  wr_data = alu;
                  cnt_d   = d - CW'(1);
                  top_d   = alu;
               end else begin
                  flt = 1'b1;
               end
            end
            OP_TRESET: begin
               cnt_d        = '0;
               top_d        = '0;
               halted_d[th] = 1'b0;
            end
            default: flt = 1'b1;
         endcase
      end
      if (flt) halted_d[th] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < THREADS; i++) count_q[i] <= '0;
         halted_q     <= '0;
         res_valid_q  <= 1'b0;
         fault_q      <= 1'b0;
         res_thread_q <= '0;
         res_top_q    <= '0;
         res_count_q  <= '0;
      end else begin
         res_valid_q <= op_valid;
         fault_q     <= op_valid & flt;
         if (op_valid) begin
            count_q[th]  <= cnt_d;
            halted_q     <= halted_d;
            res_thread_q <= th;
            res_top_q    <= top_d;
            res_count_q  <= cnt_d;
         end
      end
   end

   // Stack contents survive reset; only the write strobe is blocked.
   always_ff @(posedge clk) begin
      if (!reset && op_valid && wr_en) mem_q[th][wr_idx] <= wr_data;
   end

   assign res_valid  = res_valid_q;
   assign res_thread = res_thread_q;
   assign res_top    = res_top_q;
   assign res_count  = res_count_q;
   assign fault      = fault_q;
   assign halted     = halted_q;
endmodule

// File: tb/tb_mt_stack_unit.sv
// tb/tb_mt_stack_unit.sv - randomized self-checking bench for mt_stack_unit against a stack model
module tb_mt_stack_unit;
   localparam int WIDTH = 16, DEPTH = 4, THREADS = 2, TW = 1, CW = 3;

   logic clk = 1'b0;
   logic reset = 1'b1, op_valid = 1'b0;
   logic [TW-1:0] op_thread = '0;
   logic [3:0] op_code = '0;
   logic [CW-2:0] op_arg = '0;
   logic [WIDTH-1:0] op_data = '0;
   logic res_valid, fault;
   logic [TW-1:0] res_thread;
   logic [WIDTH-1:0] res_top;
   logic [CW-1:0] res_count;
   logic [THREADS-1:0] halted;

   mt_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_thread(op_thread),
      .op_code(op_code), .op_arg(op_arg), .op_data(op_data),
      .res_valid(res_valid), .res_thread(res_thread), .res_top(res_top),
      .res_count(res_count), .fault(fault), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   logic [15:0] mstk [2][4];
   int mcnt [2] = '{0, 0};
   logic [1:0] mhalt = 2'b00;

   logic pend_valid = 1'b0, pend_fault = 1'b0;
   int pend_thread = 0, pend_count = 0;
   logic [15:0] pend_top = '0;
   logic exp_valid = 1'b0, exp_fault = 1'b0;
   int exp_thread = 0, exp_count = 0;
   logic [15:0] exp_top = '0;
   logic [1:0] exp_halt = 2'b00;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input longint act, input longint want);
      n_total++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
   endtask

   // Stack model: entry n below the top lives at mstk[th][count-1-n].
   task automatic model_step(input logic rst, input logic v, input int th, input int code,
                             input int arg, input logic [15:0] data);
      int d;
      logic [15:0] t, a, b, r;
      logic f;
      if (rst) begin
         mcnt[0] = 0; mcnt[1] = 0; mhalt = 2'b00; pend_valid = 1'b0;
         return;
      end
      if (!v) begin
         pend_valid = 1'b0;
         return;
      end
      d = mcnt[th];
      t = (d > 0) ? mstk[th][d-1] : 16'h0;
      f = 1'b0;
      if (mhalt[th] && code != 15) f = 1'b1;
      else begin
         case (code)
            0: ;
            1: if (arg < d && d < DEPTH) begin mstk[th][d] = mstk[th][d-1-arg]; d++; end else f = 1'b1;
            2: if (d >= 1) d--; else f = 1'b1;
            3: if (arg < d) mstk[th][d-1-arg] = t; else f = 1'b1;
            8: if (d < DEPTH) begin mstk[th][d] = data; d++; end else f = 1'b1;
            9, 10, 11, 12, 13, 14: begin
               if (d >= 2) begin
                  a = mstk[th][d-2];
                  b = mstk[th][d-1];
                  case (code)
                     9:       r = a + b;
                     10:      r = a - b;
                     11:      r = a & b;
                     12:      r = a | b;
                     13:      r = a ^ b;
                     default: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                  endcase
                  mstk[th][d-2] = r;
                  d--;
               end else f = 1'b1;
            end
            15: begin d = 0; mhalt[th] = 1'b0; end
            default: f = 1'b1;
         endcase
      end
      if (f) mhalt[th] = 1'b1;
      mcnt[th] = d;
      pend_valid = 1'b1;
      pend_thread = th;
      pend_top = (d > 0) ? mstk[th][d-1] : 16'h0;
      pend_count = d;
      pend_fault = f;
   endtask

   task automatic op(input logic rst, input logic v, input int th, input int code,
                     input int arg, input int data);
      @(negedge clk);
      reset = rst;
      op_valid = v;
      op_thread = TW'(th);
      op_code = code[3:0];
      op_arg = arg[CW-2:0];
      op_data = data[15:0];
      model_step(rst, v, th, code, arg, data[15:0]);
      @(posedge clk);
      #1;
      reset = 1'b0;
      op_valid = 1'b0;
   endtask

   task automatic lit(input string name, input logic v, input int top, input int cnt,
                      input logic f, input int hlt);
      chk({name, " res_valid"}, res_valid, v);
      if (v) begin
         chk({name, " res_top"}, res_top, top);
         chk({name, " res_count"}, res_count, cnt);
         chk({name, " fault"}, fault, f);
      end
      chk({name, " halted"}, halted, hlt);
   endtask

   always @(posedge clk) begin
      exp_valid = pend_valid;
      exp_thread = pend_thread;
      exp_top = pend_top;
      exp_count = pend_count;
      exp_fault = pend_fault;
      exp_halt = mhalt;
      pend_valid = 1'b0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc res_valid", res_valid, exp_valid);
         chk("cyc halted", halted, exp_halt);
         if (exp_valid) begin
            chk("cyc res_thread", res_thread, exp_thread);
            chk("cyc res_top", res_top, exp_top);
            chk("cyc res_count", res_count, exp_count);
            chk("cyc fault", fault, exp_fault);
         end
      end
   end

   initial begin
      int th, r, code, arg, data, sel;
      logic v, rst;
      op(1, 0, 0, 0, 0, 0);
      op(1, 0, 0, 0, 0, 0);
      lit("reset", 0, 0, 0, 0, 0);
      chk("reset res_thread", res_thread, 0);
      chk("reset res_top", res_top, 0);
      chk("reset res_count", res_count, 0);
      chk("reset fault", fault, 0);
      chk_en = 1'b1;

      op(0, 1, 0, 8, 0, 5);
      op(0, 1, 0, 8, 0, 3);
      op(0, 1, 0, 10, 0, 0);  lit("sub", 1, 2, 1, 0, 0);

      op(0, 1, 0, 15, 0, 0);
      op(0, 1, 1, 15, 0, 0);
      op(0, 1, 0, 8, 0, 1);   lit("b2b t0 push", 1, 1, 1, 0, 0);
      op(0, 1, 1, 8, 0, 9);   lit("b2b t1 push", 1, 9, 1, 0, 0);
      op(0, 1, 0, 1, 0, 0);   lit("b2b t0 dup", 1, 1, 2, 0, 0);
      op(0, 1, 1, 9, 0, 0);   lit("b2b t1 add", 1, 9, 1, 1, 2);

      op(0, 1, 1, 15, 0, 0);  lit("t1 treset", 1, 0, 0, 0, 0);
      op(0, 1, 0, 15, 0, 0);
      for (int i = 1; i <= 4; i++) op(0, 1, 0, 8, 0, i);
      lit("full", 1, 4, 4, 0, 0);
      op(0, 1, 0, 8, 0, 5);   lit("overflow", 1, 4, 4, 1, 1);
      op(0, 1, 0, 2, 0, 0);   lit("halted pop", 1, 4, 4, 1, 1);
      op(0, 1, 0, 15, 0, 0);  lit("treset", 1, 0, 0, 0, 0);

      op(0, 1, 1, 15, 0, 0);
      op(0, 1, 1, 8, 0, 16'hFFFF);
      op(0, 1, 1, 8, 0, 1);
      op(0, 1, 1, 9, 0, 0);   lit("add wrap", 1, 0, 1, 0, 0);
      op(0, 1, 1, 8, 0, 16'h8000);
      op(0, 1, 1, 8, 0, 1);
      op(0, 1, 1, 14, 0, 0);  lit("lt signed", 1, 1, 2, 0, 0);
      op(0, 1, 1, 2, 0, 0);   lit("pop", 1, 0, 1, 0, 0);
      op(0, 1, 1, 3, 3, 0);   lit("put underflow", 1, 0, 1, 1, 2);
      op(0, 1, 1, 15, 0, 0);

      op(0, 1, 0, 8, 0, 7);
      op(0, 1, 0, 8, 0, 8);
      op(0, 1, 0, 3, 1, 0);   lit("put", 1, 8, 2, 0, 0);
      op(0, 1, 0, 1, 1, 0);   lit("get 1", 1, 8, 3, 0, 0);
      op(0, 1, 0, 2, 0, 0);   lit("pop after get", 1, 8, 2, 0, 0);

      op(0, 1, 0, 15, 0, 0);
      op(0, 1, 0, 8, 0, 1);
      op(0, 1, 0, 8, 0, 2);
      op(1, 1, 0, 8, 0, 5);   lit("reset with push", 0, 0, 0, 0, 0);
      chk("reset with push res_count", res_count, 0);
      op(0, 1, 0, 2, 0, 0);   lit("pop after reset", 1, 0, 0, 1, 1);
      op(0, 1, 0, 15, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         th = $urandom_range(0, 1);
         r = $urandom_range(0, 99);
         if (mhalt[th] && $urandom_range(0, 9) < 7) code = 15;
         else if (r < 30) code = 8;
         else if (r < 42) code = 2;
         else if (r < 52) code = 1;
         else if (r < 59) code = 3;
         else if (r < 85) code = $urandom_range(9, 14);
         else if (r < 88) code = $urandom_range(4, 7);
         else if (r < 93) code = 0;
         else code = 15;
         arg = $urandom_range(0, 3);
         sel = $urandom_range(0, 7);
         case (sel)
            0: data = 16'h0000;
            1: data = 16'hFFFF;
            2: data = 16'h8000;
            3: data = 16'h7FFF;
            default: data = $urandom_range(0, 65535);
         endcase
         v = ($urandom_range(0, 19) != 0);
         rst = ($urandom_range(0, 299) == 0);
         op(rst, v, th, code, arg, data);
      end

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
